// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-stage slice.
// Optional build macro used by consumers: MEM_TIMEOUT_EN (bounded memory wait).
package cpu_pkg;

    // Memory-stage controller states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Bit positions inside the 2-bit M control field
    localparam int MEM_RD = 1;
    localparam int MEM_WR = 0;

    // Load data returned when a memory access is abandoned after a timeout
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A load writes a live instruction; any cycle without
// a load is a bubble: wb_valid drops while the payload fields keep their value.
module mem_wb_reg #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              next_wb,
    input  logic [REG_W-1:0]  next_rd,
    input  logic [DATA_W-1:0] next_data,
    output logic              wb_valid,
    output logic              wb,
    output logic [REG_W-1:0]  rd,
    output logic [DATA_W-1:0] data
);

    // Load a live instruction or insert a bubble with payload held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb       <= 1'b0;
            rd       <= '0;
            data     <= '0;
        end else if (load) begin
            wb_valid <= 1'b1;
            wb       <= next_wb;
            rd       <= next_rd;
            data     <= next_data;
        end else begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_slice.sv
// Memory-stage slice of the 5-stage pipeline: ALU results pass straight to
// MEM/WB, loads/stores go over a req/ready bus while upstream is stalled.
// Build macro MEM_TIMEOUT_EN bounds the wait for mem_ready to TIMEOUT cycles.
//
// Bus handshake: mem_req/mem_we/mem_addr/mem_wdata are registered and held
// stable from the edge that enters ACCESS until the edge of the cycle in which
// mem_ready=1; that edge completes the transfer (mem_rdata sampled there) and
// drops mem_req unless a new access is accepted on the same edge.
//
// A memory op completing in the same cycle that an ALU op is presented would
// need two MEM/WB writes on one edge; the ALU op is parked in a one-entry
// pending register and written on the following edge, so nothing is lost.
module mem_slice
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              WB_in,
    input  logic [1:0]        M_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              flush,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              wb_valid,
    output logic              WB,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err,
    output mem_state_t        dbg_state
);

    if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_timeout_range
        $error("mem_slice: TIMEOUT must lie in 2..256");
    end

    mem_state_t state, state_next;

    // Decode of the current cycle
    logic accept;       // slice can take the presented instruction this edge
    logic done;         // bus transfer completes this edge
    logic abort;        // bus wait abandoned this edge (timeout build only)
    logic finish;       // memory op leaves ACCESS this edge
    logic in_ok;
    logic in_alu;
    logic in_mem;
    logic in_bad;

    // Hold registers for the memory op in flight
    logic              hold_load;
    logic              hold_wb;
    logic              hold_flush;
    logic [REG_W-1:0]  hold_rd;
    logic [DATA_W-1:0] hold_result;

    // One-entry pending ALU op (collision with a completing memory op)
    logic              pend_valid;
    logic              pend_wb;
    logic [REG_W-1:0]  pend_rd;
    logic [DATA_W-1:0] pend_data;

    // MEM/WB register write port
    logic              wbr_load;
    logic              wbr_wb;
    logic [REG_W-1:0]  wbr_rd;
    logic [DATA_W-1:0] wbr_data;

    assign dbg_state = state;
    assign finish    = done || abort;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a new memory op enters ACCESS, completion or abort returns to IDLE
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = in_mem ? ACCESS : IDLE;
        end else if (abort) begin
            state_next = IDLE;
        end
    end

    // Output/decode: stall from state and mem_ready only, plus input classification
    always_comb begin
        stall  = 1'b0;
        done   = 1'b0;
        if (state == ACCESS) begin
            stall = !mem_ready;
            done  = mem_ready;
        end
        accept = (state == IDLE) || done;
        in_ok  = valid_in && !flush;
        in_alu = accept && in_ok && (M_in == 2'b00);
        in_bad = accept && in_ok && (M_in == 2'b11);
        in_mem = accept && in_ok && (M_in[MEM_RD] ^ M_in[MEM_WR]);
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Count ACCESS cycles spent without mem_ready; cleared on entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (in_mem) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign abort = (state == ACCESS) && !mem_ready && (wait_cnt == 8'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

    // Hold the op in flight; a flush while in ACCESS marks it dead
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_load   <= 1'b0;
            hold_wb     <= 1'b0;
            hold_flush  <= 1'b0;
            hold_rd     <= '0;
            hold_result <= '0;
        end else if (in_mem) begin
            hold_load   <= M_in[MEM_RD];
            hold_wb     <= WB_in;
            hold_flush  <= 1'b0;
            hold_rd     <= rd_in;
            hold_result <= result_in;
        end else if (state == ACCESS && flush) begin
            hold_flush  <= 1'b1;
        end
    end

    // Registered bus request, held stable until the transfer finishes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (in_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= M_in[MEM_WR];
            mem_addr  <= addr_in;
            mem_wdata <= data_in;
        end else if (finish) begin
            mem_req   <= 1'b0;
        end
    end

    // Sticky error: illegal M field or abandoned memory wait
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (in_bad || abort) begin
            err <= 1'b1;
        end
    end

    // Park an ALU op that arrives while MEM/WB is taken by an older result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_wb    <= 1'b0;
            pend_rd    <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= in_alu && (finish || pend_valid);
            if (in_alu) begin
                pend_wb   <= WB_in;
                pend_rd   <= rd_in;
                pend_data <= result_in;
            end
        end
    end

    // MEM/WB source select: finishing memory op, then pending ALU op, then new ALU op
    always_comb begin
        wbr_load = 1'b0;
        wbr_wb   = hold_wb;
        wbr_rd   = hold_rd;
        wbr_data = hold_result;
        if (finish) begin
            wbr_load = !(hold_flush || flush);
            if (hold_load) begin
                wbr_data = abort ? DATA_W'(TIMEOUT_DATA) : mem_rdata;
            end
        end else if (pend_valid) begin
            wbr_load = 1'b1;
            wbr_wb   = pend_wb;
            wbr_rd   = pend_rd;
            wbr_data = pend_data;
        end else if (in_alu) begin
            wbr_load = 1'b1;
            wbr_wb   = WB_in;
            wbr_rd   = rd_in;
            wbr_data = result_in;
        end
    end

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (wbr_load),
        .next_wb   (wbr_wb),
        .next_rd   (wbr_rd),
        .next_data (wbr_data),
        .wb_valid  (wb_valid),
        .wb        (WB),
        .rd        (wb_rd),
        .data      (wb_data)
    );

endmodule

// File: tb/tb_mem_slice.sv
// Directed bench for mem_slice. Inputs change and outputs are sampled on the
// falling edge; the design acts on the rising edge.
module tb_mem_slice;
    import cpu_pkg::*;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              clk;
    logic              rst;
    logic              valid_in;
    logic              WB_in;
    logic [1:0]        M_in;
    logic [DATA_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] result_in;
    logic [REG_W-1:0]  rd_in;
    logic              flush;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              wb_valid;
    logic              WB;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              err;
    mem_state_t        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_slice #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .WB_in     (WB_in),
        .M_in      (M_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .result_in (result_in),
        .rd_in     (rd_in),
        .flush     (flush),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .wb_valid  (wb_valid),
        .WB        (WB),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        valid_in  = 1'b0;
        WB_in     = 1'b0;
        M_in      = 2'b00;
        addr_in   = '0;
        data_in   = '0;
        result_in = '0;
        rd_in     = '0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic drive_op(input logic [1:0] m, input logic wb, input logic [3:0] rd,
                            input logic [15:0] addr, input logic [15:0] data,
                            input logic [15:0] res);
        valid_in  = 1'b1;
        M_in      = m;
        WB_in     = wb;
        rd_in     = rd;
        addr_in   = addr;
        data_in   = data;
        result_in = res;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_stall",     stall,     0);
        check_eq("rst_mem_req",   mem_req,   0);
        check_eq("rst_mem_we",    mem_we,    0);
        check_eq("rst_mem_addr",  mem_addr,  0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_wb_valid",  wb_valid,  0);
        check_eq("rst_WB",        WB,        0);
        check_eq("rst_wb_rd",     wb_rd,     0);
        check_eq("rst_wb_data",   wb_data,   0);
        check_eq("rst_err",       err,       0);
        check_eq("rst_state",     dbg_state, IDLE);

        rst = 1'b1;
        cycle();
        check_eq("idle_wb_valid", wb_valid, 0);
        check_eq("idle_mem_req",  mem_req,  0);

        // ALU op: one-cycle latency into MEM/WB
        drive_op(2'b00, 1'b1, 4'h5, 16'h0000, 16'h0000, 16'h1234);
        cycle();
        idle_inputs();
        check_eq("alu_wb_valid", wb_valid, 1);
        check_eq("alu_wb_data",  wb_data,  16'h1234);
        check_eq("alu_wb_rd",    wb_rd,    4'h5);
        check_eq("alu_WB",       WB,       1);
        check_eq("alu_mem_req",  mem_req,  0);
        cycle();
        check_eq("bubble_wb_valid", wb_valid, 0);
        check_eq("bubble_wb_data",  wb_data,  16'h1234);

        // Load with mem_ready on the 3rd ACCESS cycle
        drive_op(2'b10, 1'b1, 4'h3, 16'h0040, 16'h0000, 16'hFFFF);
        cycle();
        idle_inputs();
        check_eq("ld_c1_mem_req",  mem_req,   1);
        check_eq("ld_c1_mem_we",   mem_we,    0);
        check_eq("ld_c1_mem_addr", mem_addr,  16'h0040);
        check_eq("ld_c1_stall",    stall,     1);
        check_eq("ld_c1_wb_valid", wb_valid,  0);
        check_eq("ld_c1_state",    dbg_state, ACCESS);
        cycle();
        check_eq("ld_c2_mem_addr", mem_addr, 16'h0040);
        check_eq("ld_c2_mem_req",  mem_req,  1);
        check_eq("ld_c2_stall",    stall,    1);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        check_eq("ld_c3_stall",    stall,    0);
        check_eq("ld_c3_mem_addr", mem_addr, 16'h0040);
        cycle();
        idle_inputs();
        check_eq("ld_wb_valid", wb_valid,  1);
        check_eq("ld_wb_data",  wb_data,   16'hBEEF);
        check_eq("ld_wb_rd",    wb_rd,     4'h3);
        check_eq("ld_WB",       WB,        1);
        check_eq("ld_mem_req",  mem_req,   0);
        check_eq("ld_state",    dbg_state, IDLE);

        // Store, ready on 1st ACCESS cycle, ALU op presented back-to-back
        drive_op(2'b01, 1'b0, 4'h2, 16'h0080, 16'hA5A5, 16'h1111);
        cycle();
        check_eq("st_mem_req",   mem_req,   1);
        check_eq("st_mem_we",    mem_we,    1);
        check_eq("st_mem_wdata", mem_wdata, 16'hA5A5);
        check_eq("st_mem_addr",  mem_addr,  16'h0080);
        check_eq("st_wb_valid",  wb_valid,  0);
        mem_ready = 1'b1;
        drive_op(2'b00, 1'b1, 4'h9, 16'h0000, 16'h0000, 16'h0007);
        #1;
        check_eq("st_ready_stall", stall, 0);
        cycle();
        idle_inputs();
        check_eq("st_wb_valid", wb_valid, 1);
        check_eq("st_WB",       WB,       0);
        check_eq("st_wb_rd",    wb_rd,    4'h2);
        check_eq("st_wb_data",  wb_data,  16'h1111);
        check_eq("st_done_req", mem_req,  0);
        cycle();
        check_eq("b2b_wb_valid", wb_valid, 1);
        check_eq("b2b_wb_data",  wb_data,  16'h0007);
        check_eq("b2b_wb_rd",    wb_rd,    4'h9);
        check_eq("b2b_WB",       WB,       1);
        cycle();
        check_eq("b2b_after_valid", wb_valid, 0);

        // Flush during load ACCESS: bus completes, no writeback
        drive_op(2'b10, 1'b1, 4'h6, 16'h0100, 16'h0000, 16'h0000);
        cycle();
        idle_inputs();
        flush = 1'b1;
        check_eq("fl_mem_req", mem_req, 1);
        cycle();
        flush = 1'b0;
        check_eq("fl_req_held", mem_req, 1);
        mem_ready = 1'b1;
        mem_rdata = 16'hCAFE;
        cycle();
        idle_inputs();
        check_eq("fl_wb_valid", wb_valid, 0);
        check_eq("fl_wb_data",  wb_data,  16'h0007);
        check_eq("fl_mem_req",  mem_req,  0);

        // Illegal M field: sticky error, no writeback, no access
        drive_op(2'b11, 1'b1, 4'h1, 16'h0300, 16'h0000, 16'h4444);
        cycle();
        idle_inputs();
        check_eq("ill_wb_valid", wb_valid, 0);
        check_eq("ill_err",      err,      1);
        check_eq("ill_mem_req",  mem_req,  0);
        drive_op(2'b00, 1'b1, 4'hA, 16'h0000, 16'h0000, 16'h00AA);
        cycle();
        idle_inputs();
        check_eq("post_ill_valid", wb_valid, 1);
        check_eq("post_ill_data",  wb_data,  16'h00AA);
        check_eq("err_sticky",     err,      1);

        // Flush in IDLE: input ignored
        drive_op(2'b00, 1'b1, 4'hB, 16'h0000, 16'h0000, 16'h5555);
        flush = 1'b1;
        cycle();
        idle_inputs();
        check_eq("fl_idle_valid", wb_valid, 0);
        check_eq("fl_idle_data",  wb_data,  16'h00AA);

        // Reset asserted mid-ACCESS: bus request drops at once
        drive_op(2'b10, 1'b1, 4'h4, 16'h0200, 16'h0000, 16'h0000);
        cycle();
        idle_inputs();
        check_eq("rma_mem_req_before", mem_req, 1);
        rst = 1'b0;
        #1;
        check_eq("rma_mem_req",  mem_req,   0);
        check_eq("rma_stall",    stall,     0);
        check_eq("rma_err",      err,       0);
        check_eq("rma_wb_valid", wb_valid,  0);
        check_eq("rma_mem_addr", mem_addr,  0);
        check_eq("rma_state",    dbg_state, IDLE);
        cycle();
        rst = 1'b1;
        cycle();

`ifdef MEM_TIMEOUT_EN
        // Timeout: mem_ready never asserted, abort after 8 ACCESS cycles
        drive_op(2'b10, 1'b1, 4'h7, 16'h0500, 16'h0000, 16'h0000);
        cycle();
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            check_eq("to_wait_req", mem_req, 1);
            cycle();
        end
        check_eq("to_last_req", mem_req, 1);
        cycle();
        check_eq("to_mem_req",  mem_req,   0);
        check_eq("to_err",      err,       1);
        check_eq("to_wb_valid", wb_valid,  1);
        check_eq("to_wb_data",  wb_data,   16'hDEAD);
        check_eq("to_wb_rd",    wb_rd,     4'h7);
        check_eq("to_state",    dbg_state, IDLE);
`endif

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
